// File: rtl/router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : router_pkg                                                 |
// | Brief   : Shared constants and FSM state type for the 3-port router. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package router_pkg;

    localparam int c_FIFO_DEPTH = 8;
    localparam int c_DATA_W     = 3;
    localparam int c_PTR_W      = 3;
    localparam int c_CNT_W      = 4;
    localparam int c_TIMEOUT    = 30;
    localparam int c_TMR_W      = 5;
    localparam int c_NUM_PORTS  = 3;

    typedef enum logic [2:0] {
        S_DECODE       = 3'd0,
        S_LOAD_DATA    = 3'd1,
        S_WAIT_EMPTY   = 3'd2,
        S_CHECK_PARITY = 3'd3,
        S_DROP         = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : router_fifo                                                |
// | Brief   : 8x3 output FIFO with registered read port and idle flush.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module router_fifo
    import router_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_wr_en,
    input  logic [c_DATA_W-1:0] i_wr_data,
    input  logic                i_rd_en,
    output logic [c_DATA_W-1:0] o_data,
    output logic                o_vld,
    output logic                o_full
);

    logic [c_DATA_W-1:0] r_mem [c_FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_TMR_W-1:0]  r_timer;
    logic                w_empty;
    logic                w_do_wr;
    logic                w_do_rd;
    logic                w_flush;

    assign w_empty = (r_count == '0);
    assign o_full  = (r_count == c_CNT_W'(c_FIFO_DEPTH));
    assign o_vld   = !w_empty;
    assign w_do_rd = i_rd_en && !w_empty;
    assign w_do_wr = i_wr_en && !o_full;
    // Flush on the 30th consecutive unread cycle; a flush never coincides with a read.
    assign w_flush = !w_empty && !i_rd_en && (r_timer == c_TMR_W'(c_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_timer  <= '0;
            o_data   <= '0;
        end else begin
            if (w_do_rd) begin
                o_data <= r_mem[r_rd_ptr];
            end
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_timer  <= '0;
            end else begin
                if (w_do_wr) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_do_rd) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_do_wr, w_do_rd})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
                if (w_empty || i_rd_en) begin
                    r_timer <= '0;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tt_um_router.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tt_um_router                                               |
// | Brief   : 1-to-3 packet router with parity check and per-port FIFOs. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tt_um_router
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Despite its name, rst_n is an active-high synchronous reset.
    logic rst;
    assign rst = rst_n;

    logic                    w_unused;
    logic [c_DATA_W-1:0]     w_data_in;
    logic                    w_pkt_valid;
    logic [c_NUM_PORTS-1:0]  w_rd_en;
    logic [c_NUM_PORTS-1:0]  w_wr_en;
    logic [c_NUM_PORTS-1:0]  w_fifo_vld;
    logic [c_NUM_PORTS-1:0]  w_fifo_full;
    logic [c_DATA_W-1:0]     w_fifo_data [c_NUM_PORTS];
    logic [3:0]              w_vld4;
    logic [3:0]              w_full4;

    state_t                  r_state;
    state_t                  w_next;
    logic [1:0]              r_addr;
    logic [c_DATA_W-1:0]     r_parity;
    logic                    r_par_bad;
    logic                    r_err;
    logic                    w_wr_any;
    logic [1:0]              w_wr_sel;
    logic                    w_accept_hdr;
    logic                    w_load;
    logic                    w_last;
    logic                    w_chk;
    logic                    w_busy;

    assign w_unused    = ^{ena, uio_in, ui_in[7]};
    assign w_data_in   = ui_in[2:0];
    assign w_pkt_valid = ui_in[3];
    assign w_rd_en     = ui_in[6:4];
    // Pad to four entries so address 3 indexes a harmless constant.
    assign w_vld4      = {1'b0, w_fifo_vld};
    assign w_full4     = {1'b0, w_fifo_full};
    assign w_wr_en     = w_wr_any ? c_NUM_PORTS'(3'b001 << w_wr_sel) : '0;

    for (genvar i = 0; i < c_NUM_PORTS; i++) begin : g_fifo
        router_fifo u_fifo (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_wr_en[i]),
            .i_wr_data (w_data_in),
            .i_rd_en   (w_rd_en[i]),
            .o_data    (w_fifo_data[i]),
            .o_vld     (w_fifo_vld[i]),
            .o_full    (w_fifo_full[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_DECODE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_wr_any     = 1'b0;
        w_wr_sel     = r_addr;
        w_accept_hdr = 1'b0;
        w_load       = 1'b0;
        w_last       = 1'b0;
        w_chk        = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            S_DECODE: begin
                if (w_pkt_valid) begin
                    if (w_data_in[1:0] == 2'd3) begin
                        w_next = S_DROP;
                    end else if (!w_vld4[w_data_in[1:0]]) begin
                        w_wr_any     = 1'b1;
                        w_wr_sel     = w_data_in[1:0];
                        w_accept_hdr = 1'b1;
                        w_next       = S_LOAD_DATA;
                    end else begin
                        w_next = S_WAIT_EMPTY;
                    end
                end
            end
            S_LOAD_DATA: begin
                if (w_full4[r_addr]) begin
                    w_busy = 1'b1;
                end else begin
                    w_wr_any = 1'b1;
                    if (w_pkt_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_last = 1'b1;
                        w_next = S_CHECK_PARITY;
                    end
                end
            end
            S_WAIT_EMPTY: begin
                w_busy = 1'b1;
                if (!w_vld4[r_addr]) begin
                    w_next = S_DECODE;
                end
            end
            S_CHECK_PARITY: begin
                w_busy = 1'b1;
                w_chk  = 1'b1;
                w_next = S_DECODE;
            end
            S_DROP: begin
                if (!w_pkt_valid) begin
                    w_next = S_DECODE;
                end
            end
            default: w_next = S_DECODE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_parity  <= '0;
            r_par_bad <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_DECODE && w_pkt_valid) begin
                r_addr <= w_data_in[1:0];
            end
            if (w_accept_hdr) begin
                r_parity <= w_data_in;
                r_err    <= 1'b0;
            end
            if (w_load) begin
                r_parity <= r_parity ^ w_data_in;
            end
            if (w_last) begin
                r_par_bad <= (w_data_in != r_parity);
            end
            if (w_chk) begin
                r_err <= r_par_bad;
            end
        end
    end

    assign uo_out  = {w_fifo_vld[1], w_fifo_vld[0], w_fifo_data[1], w_fifo_data[0]};
    assign uio_out = {2'b00, w_busy, r_err, w_fifo_vld[2], w_fifo_data[2]};
    assign uio_oe  = 8'b0011_1111;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_router.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_tt_um_router                                            |
// | Brief   : Directed self-checking bench for tt_um_router.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_tt_um_router;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_total = 0;
    int n_bad   = 0;

    logic [2:0] e_pkt_ok  [4] = '{3'b001, 3'b101, 3'b011, 3'b111};
    logic [2:0] e_pkt_bad [4] = '{3'b001, 3'b101, 3'b011, 3'b000};
    logic [2:0] e_tail    [6] = '{3'b101, 3'b110, 3'b111, 3'b000, 3'b001, 3'b001};

    wire [2:0] d0   = uo_out[2:0];
    wire [2:0] d1   = uo_out[5:3];
    wire [2:0] d2   = uio_out[2:0];
    wire       v0   = uo_out[6];
    wire       v1   = uo_out[7];
    wire       v2   = uio_out[3];
    wire       err  = uio_out[4];
    wire       busy = uio_out[5];

    tt_um_router dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] pk(input logic pv, input logic [2:0] d, input logic [2:0] rd);
        return {1'b0, rd, pv, d};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'h00;
        tick(2);
        check("rst_uo_out", uo_out, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'h3F);
        rst_n = 1'b0;
        tick();

        // Good packet to port 1, then read it back.
        ui_in = pk(1'b1, 3'b001, 3'b000); tick();
        ui_in = pk(1'b1, 3'b101, 3'b000); tick();
        ui_in = pk(1'b1, 3'b011, 3'b000); tick();
        ui_in = pk(1'b0, 3'b111, 3'b000); tick();
        check("busy_check_parity", 8'(busy), 8'h01);
        ui_in = 8'h00; tick();
        check("vld1_after_pkt", 8'(v1), 8'h01);
        check("err_good_pkt", 8'(err), 8'h00);
        check("busy_idle", 8'(busy), 8'h00);
        ui_in = pk(1'b0, 3'b000, 3'b010);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rd1_word%0d", i), 8'(d1), 8'(e_pkt_ok[i]));
        end
        ui_in = 8'h00;
        check("vld1_drained", 8'(v1), 8'h00);

        // Same packet with bad parity.
        ui_in = pk(1'b1, 3'b001, 3'b000); tick();
        ui_in = pk(1'b1, 3'b101, 3'b000); tick();
        ui_in = pk(1'b1, 3'b011, 3'b000); tick();
        ui_in = pk(1'b0, 3'b000, 3'b000); tick();
        check("err_during_check", 8'(err), 8'h00);
        ui_in = 8'h00; tick();
        check("err_bad_parity", 8'(err), 8'h01);
        ui_in = pk(1'b0, 3'b000, 3'b010);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rd1_bad_word%0d", i), 8'(d1), 8'(e_pkt_bad[i]));
        end
        ui_in = 8'h00;
        check("err_holds", 8'(err), 8'h01);

        // Port 0 fills up: header + 7 payloads = 8 entries.
        ui_in = pk(1'b1, 3'b000, 3'b000); tick();
        check("err_cleared_by_hdr", 8'(err), 8'h00);
        for (int i = 1; i <= 7; i++) begin
            ui_in = pk(1'b1, 3'(i), 3'b000); tick();
        end
        check("busy_fifo_full", 8'(busy), 8'h01);
        check("vld0_full", 8'(v0), 8'h01);
        ui_in = pk(1'b1, 3'b000, 3'b001); tick();
        check("busy_after_read", 8'(busy), 8'h00);
        ui_in = pk(1'b1, 3'b000, 3'b000); tick();
        check("busy_refilled", 8'(busy), 8'h01);
        ui_in = pk(1'b1, 3'b001, 3'b001); tick();
        check("rd0_word1", 8'(d0), 8'h01);
        check("busy_rd_when_full", 8'(busy), 8'h00);
        tick();
        check("rd0_word2_simul_rw", 8'(d0), 8'h02);
        check("busy_simul_rw", 8'(busy), 8'h00);
        ui_in = pk(1'b0, 3'b001, 3'b001); tick();
        check("rd0_word3", 8'(d0), 8'h03);
        check("busy_check_full_pkt", 8'(busy), 8'h01);
        ui_in = pk(1'b0, 3'b000, 3'b001); tick();
        check("rd0_word4", 8'(d0), 8'h04);
        check("err_long_pkt", 8'(err), 8'h00);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rd0_tail%0d", i), 8'(d0), 8'(e_tail[i]));
        end
        ui_in = 8'h00;
        check("vld0_drained", 8'(v0), 8'h00);

        // Port 2 soft-reset after 30 unread cycles.
        ui_in = pk(1'b1, 3'b010, 3'b000); tick();
        ui_in = pk(1'b0, 3'b010, 3'b000); tick();
        ui_in = 8'h00; tick();
        check("vld2_loaded", 8'(v2), 8'h01);
        tick(27);
        check("vld2_cycle29", 8'(v2), 8'h01);
        tick();
        check("vld2_flushed", 8'(v2), 8'h00);
        check("d2_untouched", 8'(d2), 8'h00);

        // Address 3 is dropped, then the FSM accepts the next header at once.
        ui_in = pk(1'b1, 3'b011, 3'b000); tick();
        check("busy_drop", 8'(busy), 8'h00);
        ui_in = pk(1'b1, 3'b101, 3'b000); tick();
        ui_in = pk(1'b1, 3'b010, 3'b000); tick();
        ui_in = pk(1'b0, 3'b110, 3'b000); tick();
        ui_in = 8'h00;
        check("drop_no_vld", 8'({v2, v1, v0}), 8'h00);
        check("drop_busy_end", 8'(busy), 8'h00);
        ui_in = pk(1'b1, 3'b100, 3'b000); tick();
        check("hdr_after_drop", 8'(v0), 8'h01);
        ui_in = pk(1'b0, 3'b100, 3'b000); tick();
        ui_in = 8'h00; tick();
        check("err_after_drop_pkt", 8'(err), 8'h00);

        // Header to a non-empty port waits until it drains.
        ui_in = pk(1'b1, 3'b000, 3'b000); tick();
        check("busy_wait_empty", 8'(busy), 8'h01);
        ui_in = pk(1'b1, 3'b000, 3'b001); tick();
        check("rd0_wait_word", 8'(d0), 8'h04);
        check("busy_wait_reading", 8'(busy), 8'h01);
        tick();
        ui_in = pk(1'b1, 3'b000, 3'b000);
        check("wait_no_write", 8'(v0), 8'h00);
        tick();
        check("busy_wait_released", 8'(busy), 8'h00);
        tick();
        check("hdr_after_wait", 8'(v0), 8'h01);
        ui_in = pk(1'b0, 3'b000, 3'b000); tick();
        ui_in = 8'h00; tick();
        check("err_after_wait_pkt", 8'(err), 8'h00);

        // Reset in the middle of a packet.
        ui_in = pk(1'b1, 3'b001, 3'b000); tick();
        ui_in = pk(1'b1, 3'b111, 3'b000);
        rst_n = 1'b1; tick();
        rst_n = 1'b0;
        ui_in = 8'h00;
        check("midrst_uo_out", uo_out, 8'h00);
        check("midrst_uio_out", uio_out, 8'h00);
        ui_in = pk(1'b1, 3'b010, 3'b000); tick();
        check("midrst_decode_first", 8'(v2), 8'h01);
        ui_in = 8'h00;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_um_router.md
TT_UM_ROUTER -- requirements
Module: tt_um_router

Interface
REQ-001 SHALL: clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n, input, 1, reset: synchronous and active-high (asserted when 1).
REQ-003 SHALL: ena, input, 1, ignored.
REQ-004 SHALL: ui_in, input, 8. [2:0] data_in, [3] packet_valid, [4] read_enb_0, [5] read_enb_1, [6] read_enb_2, [7] unused.
REQ-005 SHALL: uo_out, output, 8. [2:0] data_out_0, [5:3] data_out_1, [6] vld_out_0, [7] vld_out_1.
REQ-006 SHALL: uio_out, output, 8. [2:0] data_out_2, [3] vld_out_2, [4] err, [5] busy, [7:6] = 0.
REQ-007 SHALL: uio_in, input, 8, ignored.
REQ-008 SHALL: uio_oe, output, 8, constant 8'b0011_1111.

Function
REQ-009 SHALL: packet is a header word, then payload words while packet_valid=1, then one parity word on the first cycle with packet_valid=0.
- Header: data_in[1:0] = destination 0..2; data_in[2] is carried as data.
REQ-010 SHALL: parity = XOR of header and all payload words (3 bits).
REQ-011 SHALL: FSM states: DECODE, LOAD_DATA, WAIT_EMPTY, CHECK_PARITY, DROP.
REQ-012 SHALL: DECODE, packet_valid=1, addr<=2, destination FIFO empty -> latch addr, write header, parity<=header, clear err, go LOAD_DATA.
REQ-013 SHALL: DECODE, packet_valid=1, addr<=2, destination FIFO not empty -> WAIT_EMPTY.
- No write; source holds the header.
- WAIT_EMPTY returns to DECODE when that FIFO is empty.
REQ-014 SHALL: DECODE, packet_valid=1, addr=3 -> DROP.
- DROP discards words while packet_valid=1.
- DROP discards the following parity word, then returns to DECODE.
- busy=0 in DROP.
REQ-015 SHALL: LOAD_DATA, FIFO not full, packet_valid=1 -> write data_in; parity ^= data_in.
REQ-016 SHALL: LOAD_DATA, FIFO not full, packet_valid=0 -> write data_in as parity word, compare it with computed parity, go CHECK_PARITY.
REQ-017 SHALL: LOAD_DATA with FIFO full -> no write, busy=1; source holds data_in until not full.
REQ-018 SHALL: CHECK_PARITY lasts one cycle, busy=1.
- err <= (received != computed), then DECODE.
- err holds until the next accepted header.
REQ-019 SHALL: busy (combinational) = 1 in WAIT_EMPTY, CHECK_PARITY, and LOAD_DATA while the target FIFO is full; else 0.
REQ-020 SHALL: three FIFOs, 8 entries x 3 bits each, with independent read/write pointers and a 4-bit count.
- Full at 8, empty at 0.
- Simultaneous read and write on one FIFO are both performed; count unchanged.
REQ-021 SHALL: vld_out_x = FIFO x not empty (combinational).
REQ-022 SHALL: read_enb_x=1 with FIFO not empty -> data_out_x <= head word next edge; pointer advances.
- Read on empty FIFO: no effect.
- data_out_x otherwise holds its value.
REQ-023 SHALL: soft reset — FIFO x is flushed (count, pointers cleared) when vld_out_x=1 and read_enb_x=0 for 30 consecutive cycles.
- Per-FIFO 5-bit timeout counter; it clears on any read or when empty.

Reset
REQ-024 SHALL: rst_n=1 at an edge:
- state=DECODE; all FIFOs empty; pointers, counters and timeouts 0.
- data_out_0..2=0, err=0, parity=0.
- Hence vld_out_x=0 and busy=0.
REQ-025 SHALL: reset mid-packet aborts the packet; the first cycle after release is DECODE.

Structure
REQ-026 SHALL: shared package router_pkg holds state enum, FIFO depth (8), data width (3), timeout (30).
REQ-027 SHALL: one sub-module router_fifo, instantiated three times; FSM, parity and pin mapping in tt_um_router.

Verification
REQ-028 SHALL: reset -> uo_out=0, uio_out=0, uio_oe=8'h3F.
REQ-029 SHALL: header 3'b001, payloads 3'b101, 3'b011, parity 3'b111 -> vld_out_1=1, err=0.
- Reading 4 words gives data_out_1 = 001, 101, 011, 111.
REQ-030 SHALL: same packet with parity 3'b000 -> err=1 in the cycle after CHECK_PARITY.
REQ-031 SHALL: header 3'b000 plus 9 payloads, no reads -> busy=1 after the 7th payload.
- After one read_enb_0 pulse, busy=0 and loading resumes.
REQ-032 SHALL: header 3'b010 delivered, no read_enb_2 for 30 cycles -> vld_out_2=0.
REQ-033 SHALL: header 3'b011 with 2 payloads -> all vld_out=0, busy=0, FSM back in DECODE.
